projection_band_detector: RTL and testbench
===========================================

Name: projection_band_detector

Overview:
- Parametrised successor to the single-band horizontal projection stage.
- Sums binarised pixels per row inside a programmable column window and thresholds each row sum.
- Segments the frame into up to MAX_BANDS vertical bands (text lines or digit rows), each with its own top and bottom row.
- Sits after binarisation, before per-digit vertical segmentation. Publishes a stable band table once per frame.

Parameters:
IMG_WIDTH, 640, active pixels per row
IMG_HEIGHT, 480, active rows per frame
MAX_BANDS, 4, number of band slots in the table
X_W, 11, column coordinate width
Y_W, 11, row coordinate width
CNT_W, 10, row-sum width; must satisfy 2^CNT_W > IMG_WIDTH

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
vsync  in  1  frame active when high; low = blanking
clken  in  1  pixel valid strobe
bin  in  1  binarised pixel, 1 = foreground
line_left  in  X_W  first column of window, inclusive
line_right  in  X_W  last column of window, inclusive
threshold  in  CNT_W  row is "on" when row sum > threshold
min_height  in  Y_W  minimum band height in rows for a band to be kept
band_top  out  MAX_BANDS*Y_W  slot i at bits [i*Y_W +: Y_W]; top row of band i
band_bottom  out  MAX_BANDS*Y_W  bottom row of band i, same packing
band_count  out  $clog2(MAX_BANDS+1)  number of valid slots
overflow  out  1  more qualifying bands existed than slots
frame_valid  out  1  one-cycle pulse when a new table is published

Behaviour:
- Reset (reset_n low, asynchronous): all outputs, counters, working table and FSM go to 0/OUT.
- Counters (x, y):
  - Cleared while vsync = 0.
  - With vsync = 1 and clken = 1: x counts 0..IMG_WIDTH-1, then wraps to 0 and y increments.
  - vsync = 0 overrides clken in the same cycle.
- Row sum acc:
  - Cleared at x = 0 before accumulating.
  - Adds bin when line_left <= x <= line_right, both bounds inclusive.
  - If line_left > line_right the window is empty and every row sum is 0.
- Row decision: evaluated on the clken cycle with x = IMG_WIDTH-1, using sum = acc + that pixel's contribution. on = (sum > threshold).
- FSM states:
  - OUT, on: start <= y; go to IN.
  - IN, off: end = y-1 and len = end-start+1. Commit if len >= min_height, then go to OUT.
  - IN or OUT, on, and y = IMG_HEIGHT-1: close the band with end = IMG_HEIGHT-1. This applies to a single-row band too. Commit under the same rule, then go to OUT.
- Commit rule:
  - If the working count < MAX_BANDS, write start/end into slot [count] and increment count.
  - Otherwise set the working overflow flag.
  - Bands shorter than min_height are discarded silently and do not set overflow.
- Slot order: slots fill top-down in frame order.
- Publish, on the first cycle vsync is sampled low after being high (falling edge):
  - Copy the working table, count and overflow to the outputs.
  - Unused slots output 0.
  - Assert frame_valid for exactly that cycle.
  - Clear the working table and count, and force the FSM to OUT.
  - A band still open at this point (truncated frame, row IMG_HEIGHT-1 not reached) is discarded.
- Output hold: outputs are constant between publishes and are never partially updated.
- Configuration inputs (line_left, line_right, threshold, min_height) are sampled live. Change them only while vsync = 0.
- Latency: published values are available one cycle after the vsync falling edge, coincident with frame_valid.
- Reset mid-frame: all state clears. No frame_valid until a full vsync high→low transition has been observed after reset release.

Test Plan:
- Test 1, two bands: 640x480 frame, window 100..500, threshold 10, min_height 3. Rows 50..80 and 200..240 each have 40 foreground pixels in-window. At vsync fall expect band_count = 2, slot0 = (50,80), slot1 = (200,240), overflow = 0, and a single-cycle frame_valid.
- Test 2, height filter and threshold: a 2-row stripe at rows 10..11 with min_height 3 is dropped. A row with exactly 10 pixels at threshold 10 is not "on". Rows 300..310 with 11 pixels give count = 1, slot0 = (300,310).
- Test 3, overflow: MAX_BANDS = 4 with six 5-row bands spaced 20 rows apart. Expect count = 4, the first four bands in slots 0..3, and overflow = 1.
- Test 4, window edges and bottom closure: pixels only at columns 100 and 500 (inclusive bounds) give sum = 2 with threshold 1. A band at rows 470..479 closes with bottom = 479. A further run with line_left = 600, line_right = 100 gives count = 0.
- Test 5, truncated frame and reset: vsync falls at row 250 while inside a band started at row 240. Expect that band absent and earlier bands published. Assert reset_n mid-frame: outputs go to 0 immediately, and no frame_valid appears until the next complete frame.

Source files
------------

// File: rtl/projection_band_detector.sv
// Row-projection band detector: thresholds windowed row sums and segments the
// frame into up to MAX_BANDS vertical bands, publishing a band table per frame.
module projection_band_detector #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned MAX_BANDS  = 4,
  parameter int unsigned X_W        = 11,
  parameter int unsigned Y_W        = 11,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             vsync,
  input  logic                             clken,
  input  logic                             bin,
  input  logic [X_W-1:0]                   line_left,
  input  logic [X_W-1:0]                   line_right,
  input  logic [CNT_W-1:0]                 threshold,
  input  logic [Y_W-1:0]                   min_height,
  output logic [MAX_BANDS*Y_W-1:0]         band_top,
  output logic [MAX_BANDS*Y_W-1:0]         band_bottom,
  output logic [$clog2(MAX_BANDS+1)-1:0]   band_count,
  output logic                             overflow,
  output logic                             frame_valid
);

  localparam int unsigned BC_W = $clog2(MAX_BANDS + 1);

  typedef enum logic {S_OUT, S_IN} state_t;

  state_t               state, state_nxt;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic [CNT_W-1:0]     acc;
  logic                 vsync_d;
  logic                 armed;
  logic [Y_W-1:0]       start;
  logic [Y_W-1:0]       wtop [MAX_BANDS];
  logic [Y_W-1:0]       wbot [MAX_BANDS];
  logic [BC_W-1:0]      wcount;
  logic                 wovf;

  logic                 in_win_c;
  logic [CNT_W-1:0]     sum_c;
  logic                 row_end_c;
  logic                 row_on_c;
  logic                 last_row_c;
  logic                 publish_c;
  logic                 start_load_c;
  logic                 commit_c;
  logic [Y_W-1:0]       commit_top_c;
  logic [Y_W-1:0]       commit_bot_c;
  logic [Y_W:0]         len_c;
  logic                 keep_c;

  // Row sum datapath and row/frame event decode
  always_comb begin
    in_win_c   = (x >= line_left) && (x <= line_right);
    sum_c      = ((x == '0) ? '0 : acc) + CNT_W'(bin && in_win_c);
    last_row_c = (y == Y_W'(IMG_HEIGHT - 1));
    row_end_c  = vsync && clken && (x == X_W'(IMG_WIDTH - 1)) &&
                 (y <= Y_W'(IMG_HEIGHT - 1));
    row_on_c   = (sum_c > threshold);
    // armed means a blanking interval has been seen since reset
    publish_c  = !vsync && vsync_d && armed;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x       <= '0;
      y       <= '0;
      acc     <= '0;
      vsync_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (!vsync) armed <= 1'b1;
      if (!vsync) begin
        x   <= '0;
        y   <= '0;
        acc <= '0;
      end else if (clken) begin
        acc <= sum_c;
        if (x == X_W'(IMG_WIDTH - 1)) begin
          x <= '0;
          y <= y + Y_W'(1);
        end else begin
          x <= x + X_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_OUT;
    else          state <= state_nxt;
  end

  // Band tracking: open on an "on" row, close on the first "off" row or at the last row
  always_comb begin
    state_nxt    = state;
    start_load_c = 1'b0;
    commit_c     = 1'b0;
    commit_top_c = start;
    commit_bot_c = y - Y_W'(1);
    if (publish_c) begin
      state_nxt = S_OUT;
    end else if (row_end_c) begin
      if (row_on_c && last_row_c) begin
        commit_c     = 1'b1;
        commit_top_c = (state == S_IN) ? start : y;
        commit_bot_c = y;
        state_nxt    = S_OUT;
      end else if (state == S_OUT && row_on_c) begin
        start_load_c = 1'b1;
        state_nxt    = S_IN;
      end else if (state == S_IN && !row_on_c) begin
        commit_c  = 1'b1;
        state_nxt = S_OUT;
      end
    end
    len_c  = {1'b0, commit_bot_c} - {1'b0, commit_top_c} + (Y_W + 1)'(1);
    keep_c = (len_c >= {1'b0, min_height});
  end

  // Working band table, rebuilt every frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start  <= '0;
      wcount <= '0;
      wovf   <= 1'b0;
      for (int unsigned i = 0; i < MAX_BANDS; i++) begin
        wtop[i] <= '0;
        wbot[i] <= '0;
      end
    end else if (publish_c) begin
      wcount <= '0;
      wovf   <= 1'b0;
      for (int unsigned i = 0; i < MAX_BANDS; i++) begin
        wtop[i] <= '0;
        wbot[i] <= '0;
      end
    end else begin
      if (start_load_c) start <= y;
      if (commit_c && keep_c) begin
        if (wcount < BC_W'(MAX_BANDS)) begin
          for (int unsigned i = 0; i < MAX_BANDS; i++) begin
            if (wcount == BC_W'(i)) begin
              wtop[i] <= commit_top_c;
              wbot[i] <= commit_bot_c;
            end
          end
          wcount <= wcount + BC_W'(1);
        end else begin
          wovf <= 1'b1;
        end
      end
    end
  end

  // Published table: updated atomically on the vsync falling edge only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      band_top    <= '0;
      band_bottom <= '0;
      band_count  <= '0;
      overflow    <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= publish_c;
      if (publish_c) begin
        band_count <= wcount;
        overflow   <= wovf;
        for (int unsigned i = 0; i < MAX_BANDS; i++) begin
          band_top[i*Y_W +: Y_W]    <= (BC_W'(i) < wcount) ? wtop[i] : '0;
          band_bottom[i*Y_W +: Y_W] <= (BC_W'(i) < wcount) ? wbot[i] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_projection_band_detector.sv
// Directed bench for projection_band_detector on a reduced 32x64 frame.
module tb_projection_band_detector;

  localparam int unsigned W   = 32;
  localparam int unsigned H   = 64;
  localparam int unsigned MB  = 4;
  localparam int unsigned XW  = 11;
  localparam int unsigned YW  = 11;
  localparam int unsigned CW  = 10;
  localparam int unsigned BCW = $clog2(MB + 1);

  logic              clk;
  logic              reset_n;
  logic              vsync;
  logic              clken;
  logic              bin;
  logic [XW-1:0]     line_left;
  logic [XW-1:0]     line_right;
  logic [CW-1:0]     threshold;
  logic [YW-1:0]     min_height;
  logic [MB*YW-1:0]  band_top;
  logic [MB*YW-1:0]  band_bottom;
  logic [BCW-1:0]    band_count;
  logic              overflow;
  logic              frame_valid;

  int n_checks = 0;
  int n_errors = 0;

  projection_band_detector #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAX_BANDS(MB), .X_W(XW), .Y_W(YW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .clken(clken), .bin(bin),
    .line_left(line_left), .line_right(line_right), .threshold(threshold),
    .min_height(min_height), .band_top(band_top), .band_bottom(band_bottom),
    .band_count(band_count), .overflow(overflow), .frame_valid(frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Foreground pattern per test; window used in most tests is columns 4..24
  function automatic bit pix(input int t, input int x, input int y);
    case (t)
      1: begin
        if ((y >= 5 && y <= 9) || (y >= 20 && y <= 25)) return (x >= 4 && x <= 15);
        if (y == 40) return (x < 4 || x >= 25);
        return 1'b0;
      end
      2: begin
        if (y >= 2 && y <= 3)   return (x >= 4 && x <= 15);
        if (y >= 15 && y <= 17) return (x >= 4 && x <= 13);
        if (y >= 30 && y <= 40) return (x >= 4 && x <= 14);
        return 1'b0;
      end
      3: return (y >= 4 && y <= 46 && ((y - 4) % 8) < 3) && (x >= 4 && x <= 15);
      4: begin
        if (y >= 58) return (x == 3 || x == 4 || x == 24 || x == 25);
        if (y == 10) return (x == 3 || x == 4 || x == 25);
        return 1'b0;
      end
      5: return ((y >= 5 && y <= 9) || y >= 40) && (x >= 4 && x <= 15);
      6: return (y == 63) && (x >= 4 && x <= 15);
      default: return 1'b0;
    endcase
  endfunction

  task automatic cfg(input int l, input int r, input int th, input int mh);
    @(negedge clk);
    vsync = 1'b0; clken = 1'b0; bin = 1'b0;
    line_left = XW'(l); line_right = XW'(r); threshold = CW'(th); min_height = YW'(mh);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_rows(input int t, input int y0, input int y1, input bit gaps);
    for (int yy = y0; yy < y1; yy++) begin
      for (int xx = 0; xx < int'(W); xx++) begin
        if (gaps && ((xx + yy) % 7 == 3)) begin
          @(negedge clk); vsync = 1'b1; clken = 1'b0; bin = 1'b1;
        end
        @(negedge clk); vsync = 1'b1; clken = 1'b1; bin = pix(t, xx, yy);
      end
    end
  endtask

  task automatic end_frame();
    @(negedge clk); vsync = 1'b0; clken = 1'b0; bin = 1'b0;
  endtask

  task automatic wait_publish(input string tag);
    int lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (frame_valid) begin lat = k; break; end
    end
    check($sformatf("%s latency", tag), 64'(lat), 64'd1);
    @(negedge clk);
    check($sformatf("%s pulse", tag), 64'(frame_valid), 64'd0);
  endtask

  task automatic check_table(input string tag, input int cnt, input int ovf,
                             input int t0, input int b0, input int t1, input int b1,
                             input int t2, input int b2, input int t3, input int b3);
    int et[4];
    int eb[4];
    et = '{t0, t1, t2, t3};
    eb = '{b0, b1, b2, b3};
    check($sformatf("%s count", tag), 64'(band_count), 64'(cnt));
    check($sformatf("%s overflow", tag), 64'(overflow), 64'(ovf));
    for (int i = 0; i < int'(MB); i++) begin
      check($sformatf("%s top%0d", tag, i), 64'(band_top[i*YW +: YW]), 64'(et[i]));
      check($sformatf("%s bottom%0d", tag, i), 64'(band_bottom[i*YW +: YW]), 64'(eb[i]));
    end
  endtask

  initial begin
    int fv_seen;
    reset_n = 1'b0; vsync = 1'b0; clken = 1'b0; bin = 1'b0;
    line_left = '0; line_right = '0; threshold = '0; min_height = '0;
    repeat (3) @(negedge clk);
    check("reset count", 64'(band_count), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset valid", 64'(frame_valid), 64'd0);
    check("reset top", 64'(band_top), 64'd0);
    check("reset bottom", 64'(band_bottom), 64'd0);
    reset_n = 1'b1;

    // Two bands with pixel-valid gaps; row 40 has foreground only outside the window
    cfg(4, 24, 10, 3);
    run_rows(1, 0, H, 1'b1);
    check("t1 hold count", 64'(band_count), 64'd0);
    check("t1 hold valid", 64'(frame_valid), 64'd0);
    end_frame();
    wait_publish("t1");
    check_table("t1", 2, 0, 5, 9, 20, 25, 0, 0, 0, 0);

    // Short stripe dropped, sum equal to threshold is off
    cfg(4, 24, 10, 3);
    run_rows(2, 0, H, 1'b0);
    check("t2 hold count", 64'(band_count), 64'd2);
    end_frame();
    wait_publish("t2");
    check_table("t2", 1, 0, 30, 40, 0, 0, 0, 0, 0, 0);

    // Six bands into four slots
    cfg(4, 24, 10, 3);
    run_rows(3, 0, H, 1'b0);
    end_frame();
    wait_publish("t3");
    check_table("t3", 4, 1, 4, 6, 12, 14, 20, 22, 28, 30);

    // Inclusive window edges, band closed by the last row
    cfg(4, 24, 1, 3);
    run_rows(4, 0, H, 1'b0);
    end_frame();
    wait_publish("t4");
    check_table("t4", 1, 0, 58, 63, 0, 0, 0, 0, 0, 0);

    // Inverted window gives empty rows even at threshold 0
    cfg(20, 4, 0, 1);
    run_rows(1, 0, H, 1'b0);
    end_frame();
    wait_publish("t4b");
    check_table("t4b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single-row band on the last row
    cfg(4, 24, 10, 1);
    run_rows(6, 0, H, 1'b0);
    end_frame();
    wait_publish("t4c");
    check_table("t4c", 1, 0, 63, 63, 0, 0, 0, 0, 0, 0);

    // Truncated frame: open band discarded
    cfg(4, 24, 10, 3);
    run_rows(5, 0, 46, 1'b0);
    end_frame();
    wait_publish("t5");
    check_table("t5", 1, 0, 5, 9, 0, 0, 0, 0, 0, 0);

    // Mid-frame reset clears outputs at once and suppresses the next publish
    cfg(4, 24, 10, 3);
    run_rows(1, 0, 30, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst mid count", 64'(band_count), 64'd0);
    check("rst mid top", 64'(band_top), 64'd0);
    check("rst mid bottom", 64'(band_bottom), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_rows(1, 30, H, 1'b0);
    end_frame();
    fv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_valid) fv_seen++;
    end
    check("rst no publish", 64'(fv_seen), 64'd0);
    check("rst count held", 64'(band_count), 64'd0);

    cfg(4, 24, 10, 3);
    run_rows(1, 0, H, 1'b0);
    end_frame();
    wait_publish("t6");
    check_table("t6", 2, 0, 5, 9, 20, 25, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
